// File: rtl/dot_display_pkg.sv
// Shared definitions for the dot-matrix display scheduler: pattern IDs,
// controller states and scan geometry.
package dot_display_pkg;

  localparam int ROW_COUNT = 8;
  localparam int ROW_W     = $clog2(ROW_COUNT);

  localparam logic [2:0] PAT_LOAD   = 3'd0;
  localparam logic [2:0] PAT_TURN_O = 3'd1;
  localparam logic [2:0] PAT_TURN_X = 3'd2;
  localparam logic [2:0] PAT_SYM_O  = 3'd3;
  localparam logic [2:0] PAT_SYM_X  = 3'd4;
  localparam logic [2:0] PAT_WIN_O  = 3'd5;
  localparam logic [2:0] PAT_WIN_X  = 3'd6;
  localparam logic [2:0] PAT_BLANK  = 3'd7;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_PLAY  = 2'd1,
    S_WIN_O = 2'd2,
    S_WIN_X = 2'd3
  } state_e;

endpackage

// File: rtl/blink_divider.sv
// Terminal-count divider producing the blink phase: clear restarts in the
// symbol phase, enable counts and toggles at terminal count, idle parks at 0.
module blink_divider #(
  parameter int BLINK_HALF = 5000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic phase_o
);

  localparam int            CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] TC = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (clr_i) begin
      phase_d = 1'b1;
    end else if (en_i) begin
      if (cnt_q == TC) begin
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/dot_display_scheduler.sv
// Row-scan and pattern sequencing for the two 8x8 dot-matrix panels; the
// pattern ID is latched only at frame start so a frame never mixes images.
module dot_display_scheduler
  import dot_display_pkg::*;
#(
  parameter int BLINK_HALF = 5000
) (
  input  logic       clk_10000Hz,
  input  logic       reset,
  input  logic       start,
  input  logic       whosTurn,
  input  logic [1:0] gameend,
  output logic [7:0] dot_row,
  output logic [2:0] row_idx,
  output logic [2:0] pattern_sel,
  output logic       frame_start,
  output logic       blink_phase
);

  state_e           state_q, state_d;
  logic [2:0]       pat_req;
  logic             win_q, win_d;
  logic             run_q;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       dot_row_q;
  logic [2:0]       pat_q;
  logic             frame_q;
  logic             phase;

  always_ff @(posedge clk_10000Hz) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  state_d = S_PLAY;
        S_PLAY: begin
          if (gameend == 2'b01)      state_d = S_WIN_O;
          else if (gameend == 2'b10) state_d = S_WIN_X;
        end
        S_WIN_O, S_WIN_X: begin
          // The first winner stays locked until the game is reset to running.
          if (gameend == 2'b00) state_d = S_PLAY;
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_comb begin
    pat_req = PAT_BLANK;
    case (state_q)
      S_LOAD:  pat_req = PAT_LOAD;
      S_PLAY: begin
        if (gameend == 2'b11) pat_req = PAT_BLANK;
        else                  pat_req = whosTurn ? PAT_TURN_O : PAT_TURN_X;
      end
      S_WIN_O: pat_req = phase ? PAT_SYM_O : PAT_WIN_O;
      S_WIN_X: pat_req = phase ? PAT_SYM_X : PAT_WIN_X;
      default: pat_req = PAT_BLANK;
    endcase
  end

  // Blink registers follow the next state so the phase lines up with state_q.
  assign win_q = (state_q == S_WIN_O) || (state_q == S_WIN_X);
  assign win_d = (state_d == S_WIN_O) || (state_d == S_WIN_X);

  blink_divider #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk_i   (clk_10000Hz),
    .rst_n_i (reset),
    .clr_i   (win_d && !win_q),
    .en_i    (win_d && win_q),
    .phase_o (phase)
  );

  // run_q holds the scan at row 0 for the first edge out of reset.
  assign row_d = run_q ? row_q + 1'b1 : '0;

  always_ff @(posedge clk_10000Hz) begin
    if (!reset) begin
      run_q     <= 1'b0;
      row_q     <= '0;
      dot_row_q <= 8'hFF;
      pat_q     <= PAT_BLANK;
      frame_q   <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      row_q     <= row_d;
      dot_row_q <= ~(8'h80 >> row_d);
      frame_q   <= (row_d == '0);
      if (row_d == '0) pat_q <= pat_req;
    end
  end

  assign dot_row     = dot_row_q;
  assign row_idx     = row_q;
  assign pattern_sel = pat_q;
  assign frame_start = frame_q;
  assign blink_phase = phase;

endmodule

// File: tb/tb_dot_display_scheduler.sv
// Directed bench for dot_display_scheduler with a short blink period; expected
// scan outputs are queued per cycle and compared one cycle later.
module tb_dot_display_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       whosTurn;
  logic [1:0] gameend;
  logic [7:0] dot_row;
  logic [2:0] row_idx;
  logic [2:0] pattern_sel;
  logic       frame_start;
  logic       blink_phase;

  dot_display_scheduler #(
    .BLINK_HALF(10)
  ) dut (
    .clk_10000Hz (clk),
    .reset       (reset),
    .start       (start),
    .whosTurn    (whosTurn),
    .gameend     (gameend),
    .dot_row     (dot_row),
    .row_idx     (row_idx),
    .pattern_sel (pattern_sel),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] row;
    logic [7:0] dot;
    logic [2:0] pat;
    logic       fs;
    logic       bp;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] dot_tab [8];
  int         tests = 0;
  int         fails = 0;
  int         n = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, expv);
    end
  endtask

  // in_rst=1: the coming edge is a reset edge; otherwise it is scan cycle n+1.
  task automatic step(input logic in_rst, input logic [2:0] pat, input logic bp);
    exp_t e;
    if (in_rst) begin
      n = 0;
      e = '{row: 3'd0, dot: 8'hFF, pat: 3'd7, fs: 1'b0, bp: 1'b0};
    end else begin
      n++;
      e.row = 3'((n - 1) % 8);
      e.dot = dot_tab[(n - 1) % 8];
      e.pat = pat;
      e.fs  = (((n - 1) % 8) == 0);
      e.bp  = bp;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("row_idx",     {5'd0, row_idx},     {5'd0, e.row});
    chk("dot_row",     dot_row,             e.dot);
    chk("pattern_sel", {5'd0, pattern_sel}, {5'd0, e.pat});
    chk("frame_start", {7'd0, frame_start}, {7'd0, e.fs});
    chk("blink_phase", {7'd0, blink_phase}, {7'd0, e.bp});
  endtask

  task automatic run(input int k, input logic [2:0] pat, input logic bp);
    repeat (k) step(1'b0, pat, bp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    dot_tab[0] = 8'h7F; dot_tab[1] = 8'hBF; dot_tab[2] = 8'hDF; dot_tab[3] = 8'hEF;
    dot_tab[4] = 8'hF7; dot_tab[5] = 8'hFB; dot_tab[6] = 8'hFD; dot_tab[7] = 8'hFE;

    reset = 1'b0; start = 1'b1; whosTurn = 1'b1; gameend = 2'b01;
    repeat (3) step(1'b1, 3'd7, 1'b0);

    reset = 1'b1; start = 1'b0; whosTurn = 1'b0; gameend = 2'b00;
    run(12, 3'd0, 1'b0);                 // lobby frames, rows 0..3 of frame 2
    start = 1'b1; whosTurn = 1'b1;
    run(4, 3'd0, 1'b0);
    run(4, 3'd1, 1'b0);                  // TURN_O frame, rows 0..3
    whosTurn = 1'b0;
    run(4, 3'd1, 1'b0);                  // change held off until frame end
    run(1, 3'd2, 1'b0);
    gameend = 2'b01;                     // O wins
    run(7, 3'd2, 1'b1);
    run(3, 3'd3, 1'b1);
    run(5, 3'd3, 1'b0);                  // toggle 10 cycles after entry
    run(2, 3'd5, 1'b0);
    gameend = 2'b10;                     // winner stays locked
    run(3, 3'd5, 1'b0);
    run(3, 3'd5, 1'b1);
    run(7, 3'd3, 1'b1);
    run(1, 3'd3, 1'b0);
    run(2, 3'd5, 1'b0);
    gameend = 2'b00;                     // back to play, blink cleared
    run(6, 3'd5, 1'b0);
    run(2, 3'd2, 1'b0);
    gameend = 2'b11;                     // invalid -> blank
    run(6, 3'd2, 1'b0);
    run(2, 3'd7, 1'b0);
    gameend = 2'b10;                     // X wins
    run(6, 3'd7, 1'b1);
    run(2, 3'd4, 1'b1);
    start = 1'b0;                        // abort to lobby during WIN_X
    run(6, 3'd4, 1'b0);
    run(8, 3'd0, 1'b0);
    run(5, 3'd0, 1'b0);                  // rows 0..4
    reset = 1'b0; start = 1'b1; whosTurn = 1'b1; gameend = 2'b01;
    step(1'b1, 3'd7, 1'b0);              // reset at row 5
    reset = 1'b1; start = 1'b0; gameend = 2'b00;
    run(8, 3'd0, 1'b0);                  // clean restart at row 0

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
